mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, sets the RAM access cycles per transaction; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1  request from port 0 (pipeline memory stage) / port 1 (DMA/debug); held high until ack.
REQ-005 we0 / we1  input  1  1 = write, 0 = read; qualified by reqN.
REQ-006 addr0 / addr1  input  7  RAM word address.
REQ-007 wdata0 / wdata1  input  32  write data.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse to the granted port.
REQ-009 rdata  output  32  read data, valid in the ack cycle of a read.
REQ-010 stall0  output  1  pipeline stall, combinational: req0 AND NOT ack0.
REQ-011 ram_addr  output  7  RAM address.
REQ-012 ram_wre  output  1  RAM write enable, active-low (0 = write).
REQ-013 ram_wdata  output  32  RAM write data; tri-state is resolved at the top level.
REQ-014 ram_rdata  input  32  RAM read data.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, ACK.
REQ-016 IDLE: if any req is high, select a winner, latch its we/addr/wdata, load the 4-bit counter with WAIT_CYCLES-1, and go to ACCESS; otherwise remain in IDLE.
REQ-017 Arbitration SHALL be two-way round-robin: on simultaneous requests, the port not granted last wins; a lone requester always wins.
REQ-018 ACCESS: ram_addr = latched addr for the whole state; ram_wre = 0 for writes, 1 for reads; the counter decrements each cycle.
REQ-019 ACCESS exits to ACK on the cycle the counter is 0; on that edge, a read captures ram_rdata into rdata.
REQ-020 ACK: assert ackN of the winner for exactly one cycle, update last_grant, return to IDLE.
REQ-021 Latency: a request sampled in IDLE at cycle T SHALL produce ack at cycle T+1+WAIT_CYCLES.
REQ-022 Outside ACCESS: ram_wre = 1, ram_wdata = 0, ram_addr = 0.
REQ-023 rdata SHALL hold its last value until the next read completes; writes leave it unchanged.
REQ-024 A req dropped mid-transaction SHALL NOT abort it; the ack is still issued.
REQ-025 IDLE SHALL sample a req that is still high in the cycle after ACK as a new request.
REQ-026 Changes to the latched port's addr/wdata during ACCESS SHALL be ignored.
REQ-027 At most one ack SHALL be high in any cycle.

Reset
REQ-028 On reset low, asynchronously: state = IDLE, ack0/ack1 = 0, rdata = 0, counter = 0, ram_wre = 1, ram_addr = 0, ram_wdata = 0, last_grant = 1 (port 0 wins the first tie).
REQ-029 Reset during ACCESS SHALL abort the transaction with no ack, and ram_wre SHALL return to 1 without waiting for a clock edge.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enum, ADDR_W = 7 and DATA_W = 32.
REQ-031 Sub-module mem_arb_rr SHALL implement the combinational two-way round-robin pick (req0, req1, last_grant -> grant); all remaining logic stays in mem_arbiter.

Verification
REQ-032 Reset release, req0 write with addr0 = 7'h05, wdata0 = 32'hDEADBEEF, WAIT_CYCLES = 1 -> ram_wre = 0 and ram_addr = 5 for one cycle; ack0 at T+2.
REQ-033 Then req0 read at addr0 = 5 -> rdata = 32'hDEADBEEF together with ack0; stall0 high from request until ack.
REQ-034 req0 and req1 raised in the same cycle and held for two transactions each -> grant order 0, 1, 0, 1; ack0 and ack1 never high together.
REQ-035 WAIT_CYCLES = 3, req1 read -> ram_addr stable for 3 cycles; ack1 at T+4; req1 dropped after T+1 still yields ack1.
REQ-036 Reset asserted in the 2nd ACCESS cycle of a write -> ram_wre = 1 immediately; no ack; the next tie grants port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// =============================================================================
// Package     : mem_arb_pkg
// Description : Shared widths and state encoding for the two-port RAM
//               arbiter (pipeline memory stage vs. DMA/debug port).
// Revision    : 1.0 - initial release
// =============================================================================
package mem_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    // Explicitly encoded so the state register width is fixed at two bits
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// =============================================================================
// Interface   : mem_arbiter_if
// Description : Requester handshakes, shared read data, and the RAM-side bus
//               of the two-port memory arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    // Requester side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              stall0;

    // RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wre;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Environment view: drives requests, models the RAM
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, stall0,
        input  ram_addr, ram_wre, ram_wdata,
        output ram_rdata
    );

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, stall0,
        output ram_addr, ram_wre, ram_wdata,
        input  ram_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// =============================================================================
// Module      : mem_arb_rr
// Description : Combinational two-way round-robin pick. A lone requester
//               always wins; on a tie the port not granted last time wins.
// Revision    : 1.0 - initial release
// =============================================================================
module mem_arb_rr (
    input  wire logic req0,
    input  wire logic req1,
    input  wire logic last_grant,
    output logic      grant
);

    // grant = 0 selects port 0, grant = 1 selects port 1
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port RAM between the pipeline memory stage
//               (port 0) and a DMA/debug port (port 1). Each transaction is
//               IDLE -> ACCESS (WAIT_CYCLES cycles) -> ACK (one-cycle pulse).
// Revision    : 1.0 - initial release
// =============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic    clock,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    // Counter load value; the access ends on the cycle the counter reads zero
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_win;          // 0 = port 0 owns the transaction
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_last_grant;   // resets to 1 so port 0 wins the first tie

    logic w_any_req;
    logic w_grant;
    logic w_start;
    logic w_done;
    logic w_ack0;
    logic w_ack1;

    assign w_any_req = bus.req0 | bus.req1;
    assign w_start   = (r_state == IDLE) && w_any_req;
    assign w_done    = (r_state == ACCESS) && (r_cnt == '0);

    mem_arb_rr u_rr (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's command at grant so later input changes are ignored
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_win   <= w_grant;
            r_we    <= w_grant ? bus.we1    : bus.we0;
            r_addr  <= w_grant ? bus.addr1  : bus.addr0;
            r_wdata <= w_grant ? bus.wdata1 : bus.wdata0;
            r_cnt   <= c_cnt_load;
        end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Read data is captured on the last access edge and held until the next read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_done && !r_we) begin
            r_rdata <= bus.ram_rdata;
        end
    end

    // Remember who was served so the next tie goes to the other port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (r_state == ACK) begin
            r_last_grant <= r_win;
        end
    end

    // Completion pulses are decoded from the ACK state, so only one can be high
    always_comb begin
        w_ack0 = (r_state == ACK) && !r_win;
        w_ack1 = (r_state == ACK) &&  r_win;
    end

    // RAM bus is only driven during ACCESS; it idles as a non-write at address 0
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wre   = 1'b1;
        bus.ram_wdata = '0;
        if (r_state == ACCESS) begin
            bus.ram_addr  = r_addr;
            bus.ram_wre   = ~r_we;
            bus.ram_wdata = r_we ? r_wdata : '0;
        end
    end

    assign bus.ack0   = w_ack0;
    assign bus.ack1   = w_ack1;
    assign bus.rdata  = r_rdata;
    assign bus.stall0 = bus.req0 & ~w_ack0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboarded bench for mem_arbiter. Instance A (WAIT_CYCLES=1)
//               carries directed and random two-port traffic; instance B
//               (WAIT_CYCLES=3) covers long accesses and reset mid-access.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int c_wait_a  = 1;
    localparam int c_wait_b  = 3;
    localparam int c_timeout = 40;
    localparam int c_n_rand  = 40;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if bus_a ();
    mem_arbiter_if bus_b ();

    mem_arbiter #(.WAIT_CYCLES(c_wait_a)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    mem_arbiter #(.WAIT_CYCLES(c_wait_b)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + ({25'd0, a} * 32'h0000_0101);
    endfunction

    // RAM models: unwritten words read back their power-on pattern
    logic [DATA_W-1:0] mem_a [128];
    logic [DATA_W-1:0] mem_b [128];
    logic [127:0]      wr_a = '0;
    logic [127:0]      wr_b = '0;

    always @(posedge clock) begin
        if (!bus_a.ram_wre) begin
            mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
            wr_a[bus_a.ram_addr]  <= 1'b1;
        end
        if (!bus_b.ram_wre) begin
            mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
            wr_b[bus_b.ram_addr]  <= 1'b1;
        end
    end

    assign bus_a.ram_rdata = wr_a[bus_a.ram_addr] ? mem_a[bus_a.ram_addr] : init_val(bus_a.ram_addr);
    assign bus_b.ram_rdata = wr_b[bus_b.ram_addr] ? mem_b[bus_b.ram_addr] : init_val(bus_b.ram_addr);

    // Reference model: port 0 uses addresses 0..63, port 1 uses 64..127, so
    // each port's expected read data follows only from its own ordered history
    logic [DATA_W-1:0] ref_mem [128];
    exp_t              exp_q0 [$];
    exp_t              exp_q1 [$];
    int                grant_log [$];
    logic [DATA_W-1:0] model_rdata = '0;
    int                n_total = 0;
    int                n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic score(input int p);
        exp_t e;
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_ack_p%0d: got ack want none", p);
            return;
        end
        if (p == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        if (e.we) begin
            check($sformatf("rdata_kept_on_write_p%0d", p), bus_a.rdata, model_rdata);
        end else begin
            check($sformatf("read_data_p%0d", p), bus_a.rdata, e.data);
            model_rdata = e.data;
        end
        grant_log.push_back(p);
    endtask

    // Monitor for instance A: pops the scoreboard whenever an ack appears
    always @(negedge clock) begin
        if (!reset) begin
            model_rdata = '0;
        end else if (bus_a.ack0 || bus_a.ack1) begin
            check("ack_exclusive", {31'd0, bus_a.ack0 & bus_a.ack1}, 32'd0);
            check("ram_wre_idle_in_ack", {31'd0, bus_a.ram_wre}, 32'd1);
            if (bus_a.ack0) score(0);
            else            score(1);
        end
    end

    task automatic issue_a(input int p, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        exp_t e;
        e.we   = we;
        e.data = ref_mem[a];
        if (we) ref_mem[a] = d;
        if (p == 0) begin
            bus_a.req0 = 1'b1; bus_a.we0 = we; bus_a.addr0 = a; bus_a.wdata0 = d;
            exp_q0.push_back(e);
        end else begin
            bus_a.req1 = 1'b1; bus_a.we1 = we; bus_a.addr1 = a; bus_a.wdata1 = d;
            exp_q1.push_back(e);
        end
    endtask

    // Counts negedges from issue until ack; port 0 also checks stall0 each cycle
    task automatic wait_ack_a(input int p, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < c_timeout) begin
            @(negedge clock);
            n++;
            hit = (p == 0) ? bus_a.ack0 : bus_a.ack1;
            if (p == 0) check("stall0", {31'd0, bus_a.stall0}, {31'd0, ~hit});
        end
        if (!hit) begin
            n_total++;
            n_bad++;
            $display("FAIL ack_timeout_a_p%0d: got no ack in %0d cycles want ack", p, c_timeout);
        end
    endtask

    task automatic run_a(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int n);
        issue_a(p, we, a, d);
        wait_ack_a(p, n);
        @(posedge clock); #1;
        if (p == 0) bus_a.req0 = 1'b0;
        else        bus_a.req1 = 1'b0;
    endtask

    task automatic wait_ack_b(input int p, output logic hit);
        int n;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < c_timeout) begin
            @(negedge clock);
            n++;
            hit = (p == 0) ? bus_b.ack0 : bus_b.ack1;
        end
        if (!hit) begin
            n_total++;
            n_bad++;
            $display("FAIL ack_timeout_b_p%0d: got no ack in %0d cycles want ack", p, c_timeout);
        end
    endtask

    initial begin : main
        int   n;
        int   n_p0;
        int   n_p1;
        int   gap0;
        int   gap1;
        logic hit;

        bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
        bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
        bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
        bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(7'(i));

        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst_ack0", {31'd0, bus_a.ack0}, 32'd0);
        check("rst_ack1", {31'd0, bus_a.ack1}, 32'd0);
        check("rst_rdata", bus_a.rdata, 32'd0);
        check("rst_ram_wre", {31'd0, bus_a.ram_wre}, 32'd1);
        check("rst_ram_addr", {25'd0, bus_a.ram_addr}, 32'd0);
        check("rst_ram_wdata", bus_a.ram_wdata, 32'd0);
        check("rst_stall0", {31'd0, bus_a.stall0}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        // Lone write at 5; inputs scrambled once the command is latched
        issue_a(0, 1'b1, 7'h05, 32'hDEAD_BEEF);
        @(negedge clock);
        check("w_stall0_req", {31'd0, bus_a.stall0}, 32'd1);
        @(posedge clock); #1;
        bus_a.addr0  = 7'h33;
        bus_a.wdata0 = 32'h0BAD_0BAD;
        @(negedge clock);
        check("w_ram_wre", {31'd0, bus_a.ram_wre}, 32'd0);
        check("w_ram_addr", {25'd0, bus_a.ram_addr}, 32'h05);
        check("w_ram_wdata", bus_a.ram_wdata, 32'hDEAD_BEEF);
        check("w_no_early_ack", {31'd0, bus_a.ack0}, 32'd0);
        @(negedge clock);
        check("w_ack0_latency", {31'd0, bus_a.ack0}, 32'd1);
        check("w_ram_wre_released", {31'd0, bus_a.ram_wre}, 32'd1);
        check("w_ram_addr_released", {25'd0, bus_a.ram_addr}, 32'd0);
        @(posedge clock); #1;
        bus_a.req0 = 1'b0;

        // Read back; lone port 1 read then leaves last grant on port 1
        run_a(0, 1'b0, 7'h05, 32'd0, n);
        check("r_latency_p0", n, c_wait_a + 2);
        run_a(1, 1'b0, 7'h46, 32'd0, n);
        check("r_latency_p1", n, c_wait_a + 2);

        // Simultaneous requests held for two transactions each
        grant_log.delete();
        fork
            begin
                run_a(0, 1'b1, 7'h10, 32'hA0A0_0001, n_p0);
                run_a(0, 1'b0, 7'h10, 32'd0, n_p0);
            end
            begin
                run_a(1, 1'b1, 7'h50, 32'hB0B0_0002, n_p1);
                run_a(1, 1'b0, 7'h50, 32'd0, n_p1);
            end
        join
        check("tie_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check($sformatf("tie_grant_order_%0d", i), grant_log[i], i % 2);
        end

        // Random two-port traffic
        fork
            for (int k0 = 0; k0 < c_n_rand; k0++) begin
                gap0 = $urandom_range(0, 3);
                if (gap0 > 0) begin
                    repeat (gap0) @(posedge clock);
                    #1;
                end
                run_a(0, 1'($urandom_range(0, 1)), {1'b0, 6'($urandom_range(0, 63))},
                      32'($urandom), n_p0);
            end
            for (int k1 = 0; k1 < c_n_rand; k1++) begin
                gap1 = $urandom_range(0, 3);
                if (gap1 > 0) begin
                    repeat (gap1) @(posedge clock);
                    #1;
                end
                run_a(1, 1'($urandom_range(0, 1)), {1'b1, 6'($urandom_range(0, 63))},
                      32'($urandom), n_p1);
            end
        join
        repeat (3) @(posedge clock);
        check("scoreboard_empty_p0", exp_q0.size(), 0);
        check("scoreboard_empty_p1", exp_q1.size(), 0);

        // Instance B: 3-cycle read on port 1, request dropped after T+1
        #1;
        bus_b.req1 = 1'b1; bus_b.we1 = 1'b0; bus_b.addr1 = 7'h09;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            if (c == 1) bus_b.addr1 = 7'h7F;
            if (c == 2) bus_b.req1  = 1'b0;
            @(negedge clock);
            if (c < 4) begin
                check($sformatf("b_ram_addr_%0d", c), {25'd0, bus_b.ram_addr}, 32'h09);
                check($sformatf("b_ram_wre_%0d", c), {31'd0, bus_b.ram_wre}, 32'd1);
                check($sformatf("b_no_early_ack_%0d", c), {31'd0, bus_b.ack1}, 32'd0);
            end else begin
                check("b_ack1_latency", {31'd0, bus_b.ack1}, 32'd1);
                check("b_rdata", bus_b.rdata, init_val(7'h09));
                check("b_ram_addr_released", {25'd0, bus_b.ram_addr}, 32'd0);
            end
        end

        // Port 0 read so that, without reset, the next tie would go to port 1
        @(posedge clock); #1;
        bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 7'h0A;
        wait_ack_b(0, hit);
        check("b_p0_rdata", bus_b.rdata, init_val(7'h0A));
        @(posedge clock); #1;
        bus_b.req0 = 1'b0;

        // Reset in the second access cycle of a write
        @(posedge clock); #1;
        bus_b.req0 = 1'b1; bus_b.we0 = 1'b1; bus_b.addr0 = 7'h0C; bus_b.wdata0 = 32'hCAFE_F00D;
        @(posedge clock);
        @(posedge clock); #2;
        check("b_in_write_access", {31'd0, bus_b.ram_wre}, 32'd0);
        reset = 1'b0;
        #1;
        check("b_rst_ram_wre", {31'd0, bus_b.ram_wre}, 32'd1);
        check("b_rst_ram_addr", {25'd0, bus_b.ram_addr}, 32'd0);
        check("b_rst_ram_wdata", bus_b.ram_wdata, 32'd0);
        check("a_rst_rdata", bus_a.rdata, 32'd0);
        bus_b.req0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check($sformatf("b_no_ack_after_abort_%0d", c), {31'd0, bus_b.ack0 | bus_b.ack1}, 32'd0);
        end
        reset = 1'b1;

        // First tie after reset must go to port 0
        @(posedge clock); #1;
        bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 7'h0D;
        bus_b.req1 = 1'b1; bus_b.we1 = 1'b0; bus_b.addr1 = 7'h4D;
        hit = 1'b0;
        for (int c = 0; c < c_timeout && !hit; c++) begin
            @(negedge clock);
            hit = bus_b.ack0 | bus_b.ack1;
        end
        check("b_tie_after_reset_ack0", {31'd0, bus_b.ack0}, 32'd1);
        check("b_tie_after_reset_ack1", {31'd0, bus_b.ack1}, 32'd0);
        check("b_tie_after_reset_rdata", bus_b.rdata, init_val(7'h0D));
        @(posedge clock); #1;
        bus_b.req0 = 1'b0;
        wait_ack_b(1, hit);
        check("b_second_rdata", bus_b.rdata, init_val(7'h4D));
        @(posedge clock); #1;
        bus_b.req1 = 1'b0;

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
